// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared definitions for the fetch-stage program-counter logic:
//   - redir_e: redirect sources, encoded in ascending priority order so a
//     larger value always wins.
//   - Default reset and exception vectors (32-bit); the top module narrows
//     or widens them to its PC_W parameter.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        REDIR_NONE = 3'd0,
        REDIR_RAS  = 3'd1,
        REDIR_JMP  = 3'd2,
        REDIR_BR   = 3'd3,
        REDIR_EXC  = 3'd4
    } redir_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0020;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/ras_stack.sv
// ras_stack
//   Circular return-address stack.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset (pointer/count only)
//     push        - write push_data at the pointer and advance it
//     push_data   - return address to store
//     pop         - drop the top entry (ignored when empty)
//     clear       - discard all entries; has priority over push/pop
//     top         - most recently pushed entry (undefined content when empty)
//     count       - number of valid entries, saturates at RAS_DEPTH
//     empty/full  - count == 0 / count == RAS_DEPTH
//   Push while full overwrites the oldest entry: when full the write
//   pointer already sits on the oldest slot. Push and pop on the same edge
//   replace the top in place, leaving pointer and count unchanged.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned PC_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [PC_W-1:0]                  push_data,
    input  logic                             pop,
    input  logic                             clear,
    output logic [PC_W-1:0]                  top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             empty,
    output logic                             full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] ptr_inc;

    // Explicit wrap so non-power-of-two depths stay inside the buffer.
    assign top_idx = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign count = count_q;
    assign top   = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push && pop && !empty) begin
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_inc;
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; count qualifies which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Fetch-stage PC register with prioritised next-PC selection, a pending
//   redirect latch for redirects that arrive while fetch is stalled, and a
//   return-address stack used to predict jr $ra.
//   Ports:
//     clk, rst_n        - clock, synchronous active-low reset
//     enable            - fetch may advance (not stalled)
//     exc_valid         - exception redirect, honoured even when stalled
//     br_taken/br_target   - resolved taken branch
//     jmp_valid/jmp_target - jump from decode
//     ras_push/ras_push_addr - call: push return address
//     ras_pop           - jr $ra: redirect to RAS top
//     pc_out            - current fetch PC (registered, no input bypass)
//     redirect_pending  - a stalled redirect is waiting for enable
//     ras_count/ras_empty/ras_full - RAS occupancy
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEFAULT_RESET_VECTOR),
    parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(DEFAULT_EXC_VECTOR),
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             exc_valid,
    input  logic                             br_taken,
    input  logic [PC_W-1:0]                  br_target,
    input  logic                             jmp_valid,
    input  logic [PC_W-1:0]                  jmp_target,
    input  logic                             ras_push,
    input  logic [PC_W-1:0]                  ras_push_addr,
    input  logic                             ras_pop,
    output logic [PC_W-1:0]                  pc_out,
    output logic                             redirect_pending,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_empty,
    output logic                             ras_full
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

    redir_e          src;
    logic            ras_clear;
    logic            ras_do_push;
    logic            ras_do_pop;
    logic [PC_W-1:0] ras_top;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_do_push),
        .push_data (ras_push_addr),
        .pop       (ras_do_pop),
        .clear     (ras_clear),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Highest-priority raw request this cycle; a pop request only counts
    // when there is something to pop.
    always_comb begin
        src = REDIR_NONE;
        if (exc_valid) begin
            src = REDIR_EXC;
        end else if (br_taken) begin
            src = REDIR_BR;
        end else if (jmp_valid) begin
            src = REDIR_JMP;
        end else if (ras_pop && !ras_empty) begin
            src = REDIR_RAS;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        ras_clear   = 1'b0;
        ras_do_push = 1'b0;
        ras_do_pop  = 1'b0;
        if (src == REDIR_EXC) begin
            pc_d       = EXC_VECTOR;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
            ras_clear  = 1'b1;
        end else if (enable) begin
            if (pend_q) begin
                // Everything decoded alongside a pending redirect is wrong-path.
                pc_d       = pend_tgt_q;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
            end else begin
                // A push rides along with a jump (jal) but not with a taken
                // branch, which squashes the call.
                ras_do_push = ras_push && !br_taken;
                case (src)
                    REDIR_BR:  pc_d = br_target;
                    REDIR_JMP: pc_d = jmp_target;
                    REDIR_RAS: begin
                        pc_d       = ras_top;
                        ras_do_pop = 1'b1;
                    end
                    default:   pc_d = pc_q + PC_W'(INSTR_BYTES);
                endcase
            end
        end else if (!pend_q && (src == REDIR_BR || src == REDIR_JMP)) begin
            // Stalled: capture only the first branch/jump; pops are dropped.
            pend_d     = 1'b1;
            pend_tgt_d = (src == REDIR_BR) ? br_target : jmp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_out           = pc_q;
    assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed test of pc_fetch_unit with hand-computed expectations.
//   A second instance with RESET_VECTOR=0xFFFFFFFC shares the inputs and
//   shows the sequential wrap straight out of reset.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        exc_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;

    logic [31:0] pc_out;
    logic        redirect_pending;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;

    logic [31:0] w_pc_out;
    logic        w_redirect_pending;
    logic [2:0]  w_ras_count;
    logic        w_ras_empty;
    logic        w_ras_full;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .exc_valid        (exc_valid),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .ras_push         (ras_push),
        .ras_push_addr    (ras_push_addr),
        .ras_pop          (ras_pop),
        .pc_out           (pc_out),
        .redirect_pending (redirect_pending),
        .ras_count        (ras_count),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .exc_valid        (exc_valid),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .ras_push         (ras_push),
        .ras_push_addr    (ras_push_addr),
        .ras_pop          (ras_pop),
        .pc_out           (w_pc_out),
        .redirect_pending (w_redirect_pending),
        .ras_count        (w_ras_count),
        .ras_empty        (w_ras_empty),
        .ras_full         (w_ras_full)
    );

    task automatic idle(input logic en);
        enable        = en;
        exc_valid     = 1'b0;
        br_taken      = 1'b0;
        br_target     = '0;
        jmp_valid     = 1'b0;
        jmp_target    = '0;
        ras_push      = 1'b0;
        ras_push_addr = '0;
        ras_pop       = 1'b0;
    endtask

    // One active edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic pend, input logic [2:0] cnt);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, pend});
        check({tag, ".cnt"}, {29'd0, ras_count}, {29'd0, cnt});
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        idle(1'b0);
        tick();
        tick();
        check_state("reset", 32'h0040_0020, 1'b0, 3'd0);
        check("reset.empty", {31'd0, ras_empty}, 32'd1);
        check("reset.full", {31'd0, ras_full}, 32'd0);
        check("wrap.reset", w_pc_out, 32'hFFFF_FFFC);

        // Sequential fetch
        rst_n = 1'b1;
        idle(1'b1);
        tick();
        check("seq1", pc_out, 32'h0040_0024);
        check("wrap.seq", w_pc_out, 32'h0000_0000);
        tick();
        check("seq2", pc_out, 32'h0040_0028);
        tick();
        check("seq3", pc_out, 32'h0040_002C);

        // Branch during stall latched, later jump ignored
        idle(1'b0);
        br_taken = 1'b1; br_target = 32'h0040_0100;
        tick();
        check_state("stall_br", 32'h0040_002C, 1'b1, 3'd0);
        idle(1'b0);
        jmp_valid = 1'b1; jmp_target = 32'h0040_0200;
        tick();
        check_state("stall_jmp", 32'h0040_002C, 1'b1, 3'd0);
        idle(1'b1);
        tick();
        check_state("release", 32'h0040_0100, 1'b0, 3'd0);
        tick();
        check("after_rel", pc_out, 32'h0040_0104);

        // Pending redirect squashes same-edge branch and push
        idle(1'b0);
        jmp_valid = 1'b1; jmp_target = 32'h0040_0300;
        tick();
        check_state("stall_jmp2", 32'h0040_0104, 1'b1, 3'd0);
        idle(1'b1);
        br_taken = 1'b1; br_target = 32'h0040_0500;
        ras_push = 1'b1; ras_push_addr = 32'h0000_1234;
        tick();
        check_state("pend_wins", 32'h0040_0300, 1'b0, 3'd0);
        idle(1'b1);
        tick();
        check("after_pend", pc_out, 32'h0040_0304);

        // Fill RAS past capacity: A..E
        idle(1'b1);
        ras_push = 1'b1;
        ras_push_addr = 32'h0000_A000; tick();
        ras_push_addr = 32'h0000_B000; tick();
        ras_push_addr = 32'h0000_C000; tick();
        ras_push_addr = 32'h0000_D000; tick();
        check_state("push4", 32'h0040_0314, 1'b0, 3'd4);
        check("push4.full", {31'd0, ras_full}, 32'd1);
        ras_push_addr = 32'h0000_E000; tick();
        check_state("push5", 32'h0040_0318, 1'b0, 3'd4);
        check("push5.full", {31'd0, ras_full}, 32'd1);

        // Pop five times
        idle(1'b1);
        ras_pop = 1'b1;
        tick(); check_state("pop1", 32'h0000_E000, 1'b0, 3'd3);
        tick(); check_state("pop2", 32'h0000_D000, 1'b0, 3'd2);
        tick(); check_state("pop3", 32'h0000_C000, 1'b0, 3'd1);
        tick(); check_state("pop4", 32'h0000_B000, 1'b0, 3'd0);
        check("pop4.empty", {31'd0, ras_empty}, 32'd1);
        tick(); check_state("pop5_empty", 32'h0000_B004, 1'b0, 3'd0);

        // Same-edge push and pop replaces top
        idle(1'b1);
        ras_push = 1'b1; ras_push_addr = 32'h0000_2000;
        tick(); check_state("push2000", 32'h0000_B008, 1'b0, 3'd1);
        ras_pop = 1'b1; ras_push_addr = 32'h0000_1000;
        tick(); check_state("pushpop", 32'h0000_2000, 1'b0, 3'd1);
        idle(1'b1);
        ras_pop = 1'b1;
        tick(); check_state("pop_new_top", 32'h0000_1000, 1'b0, 3'd0);

        // Branch beats pop; RAS untouched
        idle(1'b1);
        ras_push = 1'b1; ras_push_addr = 32'h0000_3000;
        tick(); check_state("push3000", 32'h0000_1004, 1'b0, 3'd1);
        idle(1'b1);
        br_taken = 1'b1; br_target = 32'h0040_0800; ras_pop = 1'b1;
        tick(); check_state("br_vs_pop", 32'h0040_0800, 1'b0, 3'd1);
        idle(1'b1);
        ras_pop = 1'b1;
        tick(); check_state("pop3000", 32'h0000_3000, 1'b0, 3'd0);

        // jal: jump taken and push performed
        idle(1'b1);
        jmp_valid = 1'b1; jmp_target = 32'h0040_0900;
        ras_push = 1'b1; ras_push_addr = 32'h0000_4000;
        tick(); check_state("jal", 32'h0040_0900, 1'b0, 3'd1);
        idle(1'b1);
        ras_pop = 1'b1;
        tick(); check_state("pop4000", 32'h0000_4000, 1'b0, 3'd0);

        // Jump beats pop; no pop performed
        idle(1'b1);
        ras_push = 1'b1; ras_push_addr = 32'h0000_5000;
        tick(); check_state("push5000", 32'h0000_4004, 1'b0, 3'd1);
        idle(1'b1);
        jmp_valid = 1'b1; jmp_target = 32'h0040_0A00; ras_pop = 1'b1;
        tick(); check_state("jmp_vs_pop", 32'h0040_0A00, 1'b0, 3'd1);
        idle(1'b1);
        ras_pop = 1'b1;
        tick(); check_state("pop5000", 32'h0000_5000, 1'b0, 3'd0);

        // Exception during stall with pending redirect and 2 RAS entries
        idle(1'b1);
        ras_push = 1'b1;
        ras_push_addr = 32'h0000_6000; tick();
        ras_push_addr = 32'h0000_7000; tick();
        check_state("push2", 32'h0000_5008, 1'b0, 3'd2);
        idle(1'b0);
        br_taken = 1'b1; br_target = 32'h0040_0B00;
        tick(); check_state("pend_b00", 32'h0000_5008, 1'b1, 3'd2);
        idle(1'b0);
        exc_valid = 1'b1;
        tick(); check_state("exc_stall", 32'h8000_0180, 1'b0, 3'd0);
        check("exc.empty", {31'd0, ras_empty}, 32'd1);
        idle(1'b1);
        tick(); check("after_exc", pc_out, 32'h8000_0184);

        // Pop during stall is not latched
        idle(1'b1);
        ras_push = 1'b1; ras_push_addr = 32'h0000_8000;
        tick(); check_state("push8000", 32'h8000_0188, 1'b0, 3'd1);
        idle(1'b0);
        ras_pop = 1'b1;
        tick(); check_state("stall_pop", 32'h8000_0188, 1'b0, 3'd1);
        idle(1'b1);
        tick(); check_state("after_stall_pop", 32'h8000_018C, 1'b0, 3'd1);

        // Exception beats branch and push while running
        idle(1'b1);
        exc_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0C00;
        ras_push = 1'b1; ras_push_addr = 32'h0000_9000;
        tick(); check_state("exc_run", 32'h8000_0180, 1'b0, 3'd0);

        // Sequential wrap on the default instance
        idle(1'b1);
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        tick(); check("br_top", pc_out, 32'hFFFF_FFFC);
        idle(1'b1);
        tick(); check("wrap_seq", pc_out, 32'h0000_0000);

        // Reset during stall discards the pending redirect
        idle(1'b0);
        br_taken = 1'b1; br_target = 32'h0040_0D00;
        tick(); check_state("pend_d00", 32'h0000_0000, 1'b1, 3'd0);
        idle(1'b0);
        rst_n = 1'b0;
        tick(); check_state("rst_stall", 32'h0040_0020, 1'b0, 3'd0);
        rst_n = 1'b1;
        idle(1'b1);
        tick(); check_state("after_rst", 32'h0040_0024, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
